// File: rtl/ibex_mem_resp_buffer.sv
// Memory-side responder for an Ibex req/gnt/rvalid port in front of a
// single-cycle-latency SRAM. Requests are granted while capacity remains and
// answered strictly in order. One address window returns error responses and
// never reaches the SRAM.
module ibex_mem_resp_buffer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           INTG_WIDTH = 7,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE   = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] ERR_SIZE   = 32'h0000_1000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            gnt_stall_i,
    input  logic                            rsp_hold_i,
    input  logic                            req_i,
    output logic                            gnt_o,
    input  logic [ADDR_WIDTH-1:0]           addr_i,
    input  logic                            we_i,
    input  logic [DATA_WIDTH/8-1:0]         be_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [INTG_WIDTH-1:0]           wintg_i,
    output logic                            rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic [INTG_WIDTH-1:0]           rintg_o,
    output logic                            err_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [ADDR_WIDTH-1:0]           sram_addr_o,
    output logic [DATA_WIDTH/8-1:0]         sram_be_o,
    output logic [DATA_WIDTH-1:0]           sram_wdata_o,
    output logic [INTG_WIDTH-1:0]           sram_wintg_o,
    input  logic [DATA_WIDTH-1:0]           sram_rdata_i,
    input  logic [INTG_WIDTH-1:0]           sram_rintg_i,
    output logic [$clog2(DEPTH+1)-1:0]      outstanding_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    // Outstanding = FIFO entries + in-flight stage, tracked as its own counter.
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, rptr_q;

    // In-flight stage: one accepted request whose SRAM data arrives this cycle.
    logic                  fl_q;
    logic                  fl_we_q;
    logic                  fl_err_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [INTG_WIDTH-1:0] fifo_intg_q [DEPTH];
    logic                  fifo_err_q  [DEPTH];

    logic [ADDR_WIDTH-1:0] err_off;
    logic                  in_err;
    logic                  accept;
    logic                  fifo_empty;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic [DATA_WIDTH-1:0] fl_data;
    logic [INTG_WIDTH-1:0] fl_intg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unsigned offset compare: addresses below ERR_BASE wrap to large offsets.
    assign err_off = addr_i - ERR_BASE;
    assign in_err  = err_off < ERR_SIZE;

    assign gnt_o   = req_i & ~gnt_stall_i & (out_q < CW'(DEPTH));
    assign accept  = gnt_o;

    assign sram_req_o   = accept & ~in_err;
    assign sram_we_o    = we_i;
    assign sram_addr_o  = addr_i;
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;
    assign sram_wintg_o = wintg_i;

    // Only reads of the SRAM carry payload back; writes and errors return zero.
    assign fl_data = (fl_we_q | fl_err_q) ? '0 : sram_rdata_i;
    assign fl_intg = (fl_we_q | fl_err_q) ? '0 : sram_rintg_i;

    assign fifo_empty = (cnt_q == '0);
    assign rvalid_o   = ~rsp_hold_i & (~fifo_empty | fl_q);
    assign pop        = rvalid_o & ~fifo_empty;
    assign bypass     = rvalid_o & fifo_empty;
    assign push       = fl_q & ~bypass;

    assign outstanding_o = out_q;

    // Response payload: FIFO head first, otherwise in-flight bypass, else zero.
    always_comb begin
        rdata_o = '0;
        rintg_o = '0;
        err_o   = 1'b0;
        if (pop) begin
            rdata_o = fifo_data_q[rptr_q];
            rintg_o = fifo_intg_q[rptr_q];
            err_o   = fifo_err_q[rptr_q];
        end else if (bypass) begin
            rdata_o = fl_data;
            rintg_o = fl_intg;
            err_o   = fl_err_q;
        end
    end

    // Next-state for occupancy counters; simultaneous inc/dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        out_d = out_q;
        if (accept && !rvalid_o) begin
            out_d = out_q + 1'b1;
        end else if (rvalid_o && !accept) begin
            out_d = out_q - 1'b1;
        end
    end

    // Control state: counters, pointers and the in-flight stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q    <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fl_q     <= 1'b0;
            fl_we_q  <= 1'b0;
            fl_err_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            fl_q     <= accept;
            fl_we_q  <= accept & we_i;
            fl_err_q <= accept & in_err;
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

    // Response FIFO storage, written from the in-flight stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_intg_q[i] <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else if (push) begin
            fifo_data_q[wptr_q] <= fl_data;
            fifo_intg_q[wptr_q] <= fl_intg;
            fifo_err_q[wptr_q]  <= fl_err_q;
        end
    end

endmodule

// File: tb/tb_ibex_mem_resp_buffer.sv
// Directed bench for ibex_mem_resp_buffer with a response scoreboard and a
// simple SRAM model returning address-derived data one cycle after a read.
module tb_ibex_mem_resp_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gnt_stall, rsp_hold, req, gnt, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [6:0]  wintg;
    logic        rvalid, err;
    logic [31:0] rdata;
    logic [6:0]  rintg;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [3:0]  sram_be;
    logic [6:0]  sram_wintg;
    logic [31:0] sram_rdata = 32'h0;
    logic [6:0]  sram_rintg = 7'h0;
    logic [2:0]  outstanding;

    int n_cmp = 0;
    int n_mis = 0;

    logic [39:0] exp_q[$];
    int          out_m = 0;
    int          ngrant;

    always #5 clk = ~clk;

    ibex_mem_resp_buffer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .gnt_stall_i   (gnt_stall),
        .rsp_hold_i    (rsp_hold),
        .req_i         (req),
        .gnt_o         (gnt),
        .addr_i        (addr),
        .we_i          (we),
        .be_i          (be),
        .wdata_i       (wdata),
        .wintg_i       (wintg),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .rintg_o       (rintg),
        .err_o         (err),
        .sram_req_o    (sram_req),
        .sram_we_o     (sram_we),
        .sram_addr_o   (sram_addr),
        .sram_be_o     (sram_be),
        .sram_wdata_o  (sram_wdata),
        .sram_wintg_o  (sram_wintg),
        .sram_rdata_i  (sram_rdata),
        .sram_rintg_i  (sram_rintg),
        .outstanding_o (outstanding)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hDEAD_BEEF ^ (a - 32'h100);
    endfunction

    function automatic logic [6:0] intg_of(input logic [31:0] a);
        return 7'h2A ^ {1'b0, a[7:2]};
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8000_0FFF);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // SRAM model: read data is presented the cycle after the strobe.
    always @(posedge clk) begin
        if (sram_req && !sram_we) begin
            sram_rdata <= data_of(sram_addr);
            sram_rintg <= intg_of(sram_addr);
        end
    end

    // Scoreboard: grant prediction, in-order response data, outstanding count.
    always @(negedge clk) begin
        logic [39:0] e;
        logic        exp_gnt;
        if (!rst_n) begin
            exp_q.delete();
            out_m = 0;
        end else begin
            exp_gnt = req && !gnt_stall && (out_m < 4);
            check_eq("outstanding", outstanding, out_m);
            check_eq("gnt_model", gnt, exp_gnt);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rvalid_unexpected", rvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_data", rdata, e[31:0]);
                    check_eq("rsp_intg", rintg, e[38:32]);
                    check_eq("rsp_err", err, e[39]);
                end
            end else begin
                check_eq("idle_payload", {err, rintg, rdata}, 0);
            end
            if (req && gnt) begin
                if (is_err(addr))   exp_q.push_back({1'b1, 7'h0, 32'h0});
                else if (we)        exp_q.push_back(40'h0);
                else                exp_q.push_back({1'b0, intg_of(addr), data_of(addr)});
            end
            out_m = out_m + ((req && gnt) ? 1 : 0) - (rvalid ? 1 : 0);
        end
    end

    initial begin
        rst_n = 1'b0; gnt_stall = 1'b0; rsp_hold = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = 4'hF; wintg = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_sram_req", sram_req, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_payload", {err, rintg, rdata}, 0);
        next_cyc();
        rst_n = 1'b1;

        // Single read
        next_cyc();
        req = 1'b1; addr = 32'h100; we = 1'b0;
        @(negedge clk);
        check_eq("rd_gnt", gnt, 1);
        check_eq("rd_sram_req", sram_req, 1);
        check_eq("rd_sram_addr", sram_addr, 32'h100);
        check_eq("rd_outst0", outstanding, 0);
        next_cyc();
        req = 1'b0;
        @(negedge clk);
        check_eq("rd_rvalid", rvalid, 1);
        check_eq("rd_rdata", rdata, 32'hDEAD_BEEF);
        check_eq("rd_rintg", rintg, 7'h2A);
        check_eq("rd_err", err, 0);
        check_eq("rd_outst1", outstanding, 1);
        next_cyc();
        @(negedge clk);
        check_eq("rd_rvalid_off", rvalid, 0);
        check_eq("rd_outst2", outstanding, 0);

        // Held responses: capacity limit of 4
        next_cyc();
        rsp_hold = 1'b1;
        ngrant = 0;
        for (int i = 0; i < 6; i++) begin
            req = 1'b1; addr = 32'h200 + 32'(ngrant * 4);
            @(negedge clk);
            if (gnt) ngrant++;
            if (i < 5) next_cyc();
        end
        check_eq("hold_grants", ngrant, 4);
        check_eq("hold_gnt_low", gnt, 0);
        check_eq("hold_outst", outstanding, 4);
        next_cyc();
        // Delivery in this cycle must not free a slot yet
        rsp_hold = 1'b0;
        @(negedge clk);
        check_eq("rel_gnt_still_low", gnt, 0);
        check_eq("rel_rvalid0", rvalid, 1);
        next_cyc();
        req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check_eq("rel_rvalid", rvalid, 1);
            next_cyc();
        end
        @(negedge clk);
        check_eq("rel_drained", rvalid, 0);
        next_cyc();
        req = 1'b1; addr = 32'h240;
        @(negedge clk);
        check_eq("grant_resumes", gnt, 1);
        next_cyc();
        req = 1'b0;

        // Error region and its upper boundary
        next_cyc();
        req = 1'b1; addr = 32'h8000_0010;
        @(negedge clk);
        check_eq("err_gnt", gnt, 1);
        check_eq("err_no_sram", sram_req, 0);
        next_cyc();
        addr = 32'h8000_1000;
        @(negedge clk);
        check_eq("err_rvalid", rvalid, 1);
        check_eq("err_flag", err, 1);
        check_eq("err_rdata", rdata, 0);
        check_eq("bound_sram_req", sram_req, 1);
        next_cyc();
        addr = 32'h7FFF_FFFC;
        @(negedge clk);
        check_eq("bound_err", err, 0);
        check_eq("below_sram_req", sram_req, 1);
        next_cyc();
        req = 1'b0;

        // Write pass-through
        next_cyc();
        req = 1'b1; we = 1'b1; addr = 32'h300; be = 4'b0011;
        wdata = 32'h1234_5678; wintg = 7'h55;
        @(negedge clk);
        check_eq("wr_sram_we", sram_we, 1);
        check_eq("wr_sram_addr", sram_addr, 32'h300);
        check_eq("wr_sram_be", sram_be, 4'b0011);
        check_eq("wr_sram_wdata", sram_wdata, 32'h1234_5678);
        check_eq("wr_sram_wintg", sram_wintg, 7'h55);
        next_cyc();
        req = 1'b0; we = 1'b0; be = 4'hF;
        @(negedge clk);
        check_eq("wr_rvalid", rvalid, 1);
        check_eq("wr_rdata", rdata, 0);

        // Toggling grant stall with mixed reads/writes/errors
        ngrant = 0;
        for (int i = 0; i < 20; i++) begin
            next_cyc();
            gnt_stall = i[0];
            req = 1'b1;
            we = (ngrant % 4 == 1);
            addr = (ngrant % 3 == 2) ? 32'h8000_0000 + 32'(ngrant * 4)
                                     : 32'h400 + 32'(ngrant * 4);
            @(negedge clk);
            check_eq("stall_gnt", gnt, !gnt_stall);
            if (gnt) ngrant++;
        end
        check_eq("stall_grants", ngrant, 10);
        next_cyc();
        req = 1'b0; we = 1'b0; gnt_stall = 1'b0;
        next_cyc();
        next_cyc();

        // Asynchronous reset with three outstanding
        rsp_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; addr = 32'h500 + 32'(i * 4);
            next_cyc();
        end
        req = 1'b0;
        #1;
        check_eq("pre_rst_outst", outstanding, 3);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_outst", outstanding, 0);
        rsp_hold = 1'b0;
        @(negedge clk);
        check_eq("in_rst_gnt", gnt, 0);
        check_eq("in_rst_rvalid", rvalid, 0);
        next_cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_rvalid", rvalid, 0);
            next_cyc();
        end

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
